// File: rtl/gray_pkg.sv
// Shared constants and conversion helpers for the Gray/binary codec.
// Helpers work on a wide word; callers zero-extend and truncate to their own WIDTH.
package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Zero-extension is transparent to all three helpers, so one wide word serves any WIDTH up to this.
    localparam int GRAY_MAX_W = 64;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic onehot_or_zero(input gray_word_t v);
        return (v & (v - gray_word_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// Per-mode Gray step checker: flags accepted values that move more than one bit
// from the previous value of the same mode, and keeps a saturating error count.
module gray_step_check
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic             mode,
    input  logic [WIDTH-1:0] gray_val,
    output logic             step_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] hist [2];
    logic [1:0]       hist_valid;
    logic [WIDTH-1:0] diff;
    logic             cnt_max;

    assign diff     = gray_val ^ hist[mode];
    // A beat accepted alongside clear starts a fresh history, so it is never flagged.
    assign step_err = !clear && hist_valid[mode] && !onehot_or_zero(gray_word_t'(diff));
    assign cnt_max  = &err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist[0]    <= '0;
            hist[1]    <= '0;
            hist_valid <= '0;
        end else begin
            if (clear) begin
                hist_valid <= '0;
            end
            if (accept) begin
                hist[mode]       <= gray_val;
                hist_valid[mode] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clear) begin
            err_cnt <= '0;
        end else if (accept && step_err && !cnt_max) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage streaming Gray<->binary converter with per-beat direction select
// and an optional Gray step checker for CDC pointer monitoring.
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit CHECK_EN = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_step_err,
    output logic [CNT_W-1:0] err_cnt
);

    // Handshake: a beat moves when valid & ready are both high at a rising edge.
    // Once out_valid is raised it stays high with stable data until out_ready takes it;
    // in_valid/in_data may change freely while in_ready is low.

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_mode;
    logic             s1_err;
    logic             s2_valid;

    logic             s2_load;
    logic             s1_advance;
    logic             accept;
    logic [WIDTH-1:0] in_gray;
    logic             in_step_err;
    logic [WIDTH-1:0] s1_conv;

    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;
    assign out_valid  = s2_valid;

    // The checker always looks at the Gray-domain view of the incoming beat.
    assign in_gray = (in_mode == MODE_B2G) ? WIDTH'(bin2gray(gray_word_t'(in_data))) : in_data;

    assign s1_conv = (s1_mode == MODE_B2G) ? WIDTH'(bin2gray(gray_word_t'(s1_data)))
                                           : WIDTH'(gray2bin(gray_word_t'(s1_data)));

    generate
        if (CHECK_EN) begin : g_check
            gray_step_check #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_step_check (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (clear),
                .accept   (accept),
                .mode     (in_mode),
                .gray_val (in_gray),
                .step_err (in_step_err),
                .err_cnt  (err_cnt)
            );
        end else begin : g_no_check
            assign in_step_err = 1'b0;
            assign err_cnt     = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
            s1_err   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
                s1_err  <= in_step_err;
            end
        end
    end

    // Output registers only change on a load that carries a beat, so a stalled beat holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            out_data     <= '0;
            out_mode     <= 1'b0;
            out_step_err <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= s1_conv;
                out_mode     <= s1_mode;
                out_step_err <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench for gray_codec_pipe: scoreboard of expected beats plus
// per-scenario inline checks; a second instance with CNT_W = 2 covers saturation.
module tb_gray_codec_pipe;

    localparam int W  = 4;
    localparam int EW = W + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         clear = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid, out_mode, out_step_err;
    logic [W-1:0] out_data;
    logic [7:0]   err_cnt;

    logic         in_ready_s, out_valid_s, out_mode_s, out_step_err_s;
    logic [W-1:0] out_data_s;
    logic [1:0]   err_cnt_s;

    always #5 clk = ~clk;

    gray_codec_pipe #(.WIDTH(W), .CHECK_EN(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_step_err(out_step_err), .err_cnt(err_cnt)
    );

    gray_codec_pipe #(.WIDTH(W), .CHECK_EN(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_mode(in_mode), .clear(clear),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_mode(out_mode_s), .out_step_err(out_step_err_s), .err_cnt(err_cnt_s)
    );

    int n_checks = 0;
    int n_fails = 0;
    int n_delivered = 0;

    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  got_q[$];
    logic          flag_q[$];
    logic [EW-1:0] mon_exp;

    logic [W-1:0] m_hist[2];
    logic         m_hv[2];
    int           m_cnt;

    function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] m_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_hist[0] = '0; m_hist[1] = '0;
        m_hv[0] = 1'b0; m_hv[1] = 1'b0;
        m_cnt = 0;
    endtask

    // Monitor: samples just before each rising edge, when a delivery is about to happen.
    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid && out_ready) begin
            n_delivered++;
            got_q.push_back(out_data);
            flag_q.push_back(out_step_err);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_beat: got err/mode/data=%b/%b/%b, required no beat",
                         out_step_err, out_mode, out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_step_err, out_mode, out_data} !== mon_exp) begin
                    n_fails++;
                    $display("FAIL scoreboard: got err/mode/data=%b, required %b",
                             {out_step_err, out_mode, out_data}, mon_exp);
                end
            end
        end
    end

    // Drives one beat starting at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic mode, input logic [W-1:0] data, input logic clr);
        logic [W-1:0] gv, res;
        logic err;
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_mode = mode; in_data = data; clear = clr;
        for (int t = 0; t < 50 && !done; t++) begin
            #4;
            if (in_ready) begin
                gv  = mode ? m_b2g(data) : data;
                res = mode ? m_b2g(data) : m_g2b(data);
                err = !clr && m_hv[mode] && ($countones(gv ^ m_hist[mode]) > 1);
                if (clr) begin
                    m_hv[0] = 1'b0; m_hv[1] = 1'b0; m_cnt = 0;
                end
                m_hist[mode] = gv;
                m_hv[mode] = 1'b1;
                if (err) m_cnt++;
                exp_q.push_back({err, mode, res});
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_checks++; n_fails++;
            $display("FAIL send_timeout: in_ready stayed 0, required acceptance within 50 cycles");
        end
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_hv[0] = 1'b0; m_hv[1] = 1'b0; m_cnt = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_mode, out_step_err, out_data} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got valid/mode/err/data=%b, required 0",
                     {out_valid, out_mode, out_step_err, out_data});
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fails++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(1'b0, 4'b0110, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("FAIL latency_early: got out_valid=%b, required 0", out_valid);
        end
        send(1'b1, 4'b1011, 1'b0);
        n_checks++;
        if ({out_valid, out_mode, out_data} !== {1'b1, 1'b0, 4'b0100}) begin
            n_fails++;
            $display("FAIL basic_g2b: got valid/mode/data=%b, required 1_0_0100", {out_valid, out_mode, out_data});
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_mode, out_data} !== {1'b1, 1'b1, 4'b1110}) begin
            n_fails++;
            $display("FAIL basic_b2g: got valid/mode/data=%b, required 1_1_1110", {out_valid, out_mode, out_data});
        end
        drain();
    endtask

    task automatic test_round_trip();
        logic [W-1:0] g [16];
        int n_err;
        clear_pulse();
        got_q.delete(); flag_q.delete();
        for (int i = 0; i < 16; i++) send(1'b1, W'(i), 1'b0);
        drain();
        n_err = 0;
        foreach (flag_q[i]) if (flag_q[i] !== 1'b0) n_err++;
        n_checks++;
        if (n_err != 0 || flag_q.size() != 16) begin
            n_fails++;
            $display("FAIL sweep_flags: got %0d flags over %0d beats, required 0 over 16", n_err, flag_q.size());
        end
        for (int i = 0; i < 16; i++) g[i] = (i < got_q.size()) ? got_q[i] : '0;
        got_q.delete(); flag_q.delete();
        for (int i = 0; i < 16; i++) send(1'b0, g[i], 1'b0);
        drain();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== W'(i)) begin
                n_fails++;
                $display("FAIL round_trip[%0d]: got %b, required %b", i,
                         (i < got_q.size()) ? got_q[i] : 4'bxxxx, W'(i));
            end
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fails++; $display("FAIL sweep_err_cnt: got %0d, required 0", err_cnt);
        end
    endtask

    task automatic test_step_err();
        logic exp_f [7];
        exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        clear_pulse();
        flag_q.delete();
        send(1'b0, 4'b0000, 1'b0);
        send(1'b0, 4'b0001, 1'b0);
        send(1'b0, 4'b0011, 1'b0);
        send(1'b0, 4'b0011, 1'b0);
        send(1'b0, 4'b0101, 1'b0);
        drain();
        n_checks++;
        if (err_cnt !== 8'd1 || err_cnt !== 8'(m_cnt)) begin
            n_fails++; $display("FAIL step_err_cnt: got %0d, required 1", err_cnt);
        end
        send(1'b0, 4'b1111, 1'b1);
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fails++; $display("FAIL clear_err_cnt: got %0d, required 0", err_cnt);
        end
        send(1'b0, 4'b1110, 1'b0);
        drain();
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (i >= flag_q.size() || flag_q[i] !== exp_f[i]) begin
                n_fails++;
                $display("FAIL step_flag[%0d]: got %b, required %b", i,
                         (i < flag_q.size()) ? flag_q[i] : 1'bx, exp_f[i]);
            end
        end
        n_checks++;
        if (err_cnt !== 8'd0) begin
            n_fails++; $display("FAIL post_clear_err_cnt: got %0d, required 0", err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] bd [5];
        logic         bm [5];
        logic [W-1:0] hold;
        int base;
        for (int i = 0; i < 5; i++) begin
            bd[i] = W'($urandom_range(0, 15));
            bm[i] = 1'($urandom_range(0, 1));
        end
        base = n_delivered;
        got_q.delete();
        out_ready = 1'b0;
        send(bm[0], bd[0], 1'b0);
        send(bm[1], bd[1], 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fails++; $display("FAIL bp_in_ready: got %b, required 0 with 2 beats buffered", in_ready);
        end
        hold = out_data;
        n_checks++;
        if (out_valid !== 1'b1 || hold !== exp_q[0][W-1:0]) begin
            n_fails++;
            $display("FAIL bp_head: got valid/data=%b/%b, required 1/%b", out_valid, hold, exp_q[0][W-1:0]);
        end
        fork
            begin
                send(bm[2], bd[2], 1'b0);
                send(bm[3], bd[3], 1'b0);
                send(bm[4], bd[4], 1'b0);
            end
            begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_data !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        n_fails++;
                        $display("FAIL bp_hold: got valid/data/in_ready=%b/%b/%b, required 1/%b/0",
                                 out_valid, out_data, in_ready, hold);
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (n_delivered - base != 5) begin
            n_fails++; $display("FAIL bp_count: got %0d beats, required 5", n_delivered - base);
        end
    endtask

    task automatic test_saturation();
        clear_pulse();
        send(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0);
        drain();
        n_checks++;
        if (err_cnt_s !== 2'd3) begin
            n_fails++; $display("FAIL sat_err_cnt: got %0d, required 3", err_cnt_s);
        end
        n_checks++;
        if (err_cnt !== 8'd5 || err_cnt !== 8'(m_cnt)) begin
            n_fails++; $display("FAIL wide_err_cnt: got %0d, required 5", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_pulse();
        out_ready = 1'b1;
        send(1'b0, 4'b0000, 1'b0);
        send(1'b1, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, out_mode, out_step_err, out_data} !== '0 || err_cnt !== 8'd0) begin
            n_fails++;
            $display("FAIL mid_reset: got valid/mode/err/data=%b cnt=%0d, required all 0",
                     {out_valid, out_mode, out_step_err, out_data}, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        flag_q.delete();
        send(1'b0, 4'b1111, 1'b0);
        send(1'b1, 4'b0101, 1'b0);
        drain();
        n_checks++;
        if (flag_q.size() != 2 || flag_q[0] !== 1'b0 || flag_q[1] !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_flags: got %0d beats flags=%b%b, required 2 beats flags=00",
                     flag_q.size(), (flag_q.size() > 0) ? flag_q[0] : 1'bx,
                     (flag_q.size() > 1) ? flag_q[1] : 1'bx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_round_trip();
        test_step_err();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
- Streaming, parametrised Gray/binary converter with a 2-stage valid/ready pipeline.
- Direction is selected per beat: Gray->binary or binary->Gray.
- A built-in Gray step checker flags any consecutive Gray-domain values that differ in more than one bit, so the block can sit at CDC pointer crossings.
- An error counter is provided for debug readback.

Parameters:
- WIDTH, 4, data width in bits (>=2).
- CHECK_EN, 1, 1 = step checker and err_cnt present; 0 = out_step_err and err_cnt tied to 0.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  value to convert.
- in_mode  input  1  0 = Gray->binary, 1 = binary->Gray.
- clear  input  1  synchronous clear of checker history and err_cnt.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  converted value.
- out_mode  output  1  mode of this beat.
- out_step_err  output  1  this beat violated single-bit step.
- err_cnt  output  CNT_W  saturating count of step errors.

Behaviour:
- Reset (rst_n low, async): all outputs and internal state are 0, including out_valid, out_data, out_mode, out_step_err, err_cnt, stage valids and history valids.
- in_ready is 1 after reset release.
- Conversion (combinational within a stage):
  - Gray->binary: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i] for i = W-2 down to 0.
  - Binary->Gray: g = b ^ (b >> 1).
- Transfer rules: a beat is accepted when in_valid & in_ready; it is delivered when out_valid & out_ready.
- Pipeline:
  - S1 registers in_data, in_mode and the step-check result.
  - S2 registers out_data, out_mode and out_step_err.
  - Latency is exactly 2 cycles from acceptance to out_valid when there is no backpressure.
  - Throughput is 1 beat/cycle.
- Backpressure:
  - S2 loads when S2 is empty or out_ready = 1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid | s1_advance.
  - While out_valid = 1 and out_ready = 0, out_data, out_mode and out_step_err hold stable.
  - With out_ready held low, at most 2 beats are buffered; in_ready then drops to 0.
- Step checker (CHECK_EN = 1), evaluated at acceptance:
  - Gray-domain value gv = in_data in mode 0; gv = converted Gray in mode 1.
  - One history register plus a hist_valid bit is kept per mode.
  - Error when hist_valid[mode] and popcount(gv ^ hist[mode]) > 1.
  - A repeated value (xor == 0) is not an error.
  - On every accepted beat, hist[mode] <= gv and hist_valid[mode] <= 1.
  - The first beat per mode after reset or clear is never flagged.
  - Wrap-around is treated as a normal step: mode 0 Gray 1000 -> 0000 is 1 bit, so no error.
- err_cnt:
  - Increments by 1 when an errored beat is accepted.
  - Saturates at 2^CNT_W - 1.
- clear:
  - Sets both hist_valid to 0 and err_cnt to 0.
  - A beat accepted in the same cycle is not checked, not counted, and becomes the new history.
  - clear takes priority over increment.
  - In-flight beats are unaffected.
- Reset mid-operation: in-flight beats are discarded and out_valid drops immediately (async).
- Mode may change on any beat; there is no bubble between beats of different modes.

Decomposition:
- Shared package gray_pkg:
  - MODE_G2B = 1'b0 and MODE_B2G = 1'b1 constants.
  - Functions gray2bin(), bin2gray() and onehot_or_zero() (popcount <= 1).
- One sub-module, gray_step_check:
  - Contains the history registers, hist_valid, error compare and err_cnt.
  - Instantiated under CHECK_EN.

Test Plan:
- WIDTH = 4, out_ready = 1.
  - Stimulus: mode 0, in 0110 -> out 0100 two cycles after acceptance. Then mode 1, in 1011 -> out 1110 on the next cycle.
- Exhaustive round trip.
  - Stimulus: feed all 16 values in mode 1, then loop each output back in mode 0 -> each recovered value equals the original.
  - out_step_err stays 0 for the ordered binary->Gray sweep 0..15.
- Step errors.
  - Stimulus: mode 0 sequence 0000, 0001, 0011, 0011, 0101 -> out_step_err = 0, 0, 0, 0, 1 and err_cnt = 1.
  - Then clear with in 1111 accepted in the same cycle -> that beat has no flag and err_cnt = 0. The next beat 1110 has no flag.
- Backpressure.
  - Stimulus: stream 5 beats with out_ready low for 4 cycles.
  - Required: in_ready = 0 after 2 beats buffered, out_data held stable, all 5 beats delivered in order with none lost or duplicated.
- Saturation with CNT_W = 2.
  - Stimulus: 5 errored beats -> err_cnt = 3.
- Reset mid-stream.
  - Stimulus: drop rst_n while 2 beats are in flight -> outputs are 0 immediately.
  - After release, the first beat in each mode is unflagged.
